// File: rtl/cdc_rr_hs_sender.sv
`default_nettype none
// ============================================================================
//  Module   : cdc_rr_hs_sender
//  Brief    : Round-robin arbiter feeding one shared 4-phase req/ack crossing.
//  Revision : 1.0
// ============================================================================
module cdc_rr_hs_sender #(
    parameter  int NCH    = 4,
    parameter  int DW     = 8,
    parameter  int SYNC_N = 2,
    parameter  int TO_W   = 8,
    localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NCH-1:0]    in_valid,
    output logic [NCH-1:0]    in_ready,
    input  logic [NCH*DW-1:0] in_data,
    output logic              xreq,
    output logic [DW-1:0]     xdata,
    output logic [CW-1:0]     xch,
    input  logic              xack,
    output logic              busy,
    output logic              err,
    input  logic              err_clr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_REL  = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] TO_LIM = '1;
    localparam logic [TO_W-1:0] TO_PRE = TO_LIM - TO_W'(1);

    state_t              state_q, state_d;
    logic [CW-1:0]       rr_q, rr_d;
    logic [SYNC_N-1:0]   sync_q, sync_d;
    logic [TO_W-1:0]     cnt_q, cnt_d;
    logic                xreq_q, xreq_d;
    logic [DW-1:0]       xdata_q, xdata_d;
    logic [CW-1:0]       xch_q, xch_d;
    logic                err_q, err_d;

    logic                ack_s;
    logic                grant_found;
    logic [CW-1:0]       grant_idx;
    logic [CW:0]         rr_sum;
    logic [DW-1:0]       grant_data;
    logic                accept;
    logic                to_hit;

    assign sync_d = {sync_q[SYNC_N-2:0], xack};
    assign ack_s  = sync_q[SYNC_N-1];

    // Search from rr_q upward, wrapping at NCH so non-power-of-2 counts never alias.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        rr_sum      = '0;
        for (int k = 0; k < NCH; k++) begin
            rr_sum = {1'b0, rr_q} + (CW+1)'(k);
            if (rr_sum >= (CW+1)'(NCH)) begin
                rr_sum = rr_sum - (CW+1)'(NCH);
            end
            if (!grant_found && in_valid[rr_sum[CW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = rr_sum[CW-1:0];
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant_idx == CW'(i)) begin
                grant_data = in_data[i*DW +: DW];
            end
        end
    end

    assign accept = (state_q == S_IDLE) && !ack_s && grant_found;

    always_comb begin
        in_ready = '0;
        if (accept) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        xreq_d  = xreq_q;
        xdata_d = xdata_q;
        xch_d   = xch_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        to_hit  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    xdata_d = grant_data;
                    xch_d   = grant_idx;
                    xreq_d  = 1'b1;
                    rr_d    = (grant_idx == CW'(NCH-1)) ? '0 : grant_idx + CW'(1);
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (ack_s) begin
                    xreq_d  = 1'b0;
                    state_d = S_REL;
                end
            end
            S_REL: begin
                if (!ack_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                xreq_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        // Clearing a latched error re-arms the timeout so a still-stuck handshake reports again.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q != S_IDLE) begin
            if (cnt_q == TO_PRE) begin
                to_hit = 1'b1;
                cnt_d  = TO_LIM;
            end else if (err_clr && err_q) begin
                cnt_d = '0;
            end else if (cnt_q != TO_LIM) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (to_hit) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            sync_q  <= '0;
            cnt_q   <= '0;
            xreq_q  <= 1'b0;
            xdata_q <= '0;
            xch_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            xreq_q  <= xreq_d;
            xdata_q <= xdata_d;
            xch_q   <= xch_d;
            err_q   <= err_d;
        end
    end

    assign xreq  = xreq_q;
    assign xdata = xdata_q;
    assign xch   = xch_q;
    assign err   = err_q;
    assign busy  = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cdc_rr_hs_sender.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cdc_rr_hs_sender
//  Brief    : Scoreboard bench for cdc_rr_hs_sender with a 3-cycle echo destination.
//  Revision : 1.0
// ============================================================================
module tb_cdc_rr_hs_sender;

    localparam int NCH     = 4;
    localparam int DW      = 8;
    localparam int SYNC_N  = 2;
    localparam int TO_W    = 4;
    localparam int DST_DLY = 3;

    logic          clk      = 1'b0;
    logic          rstn     = 1'b0;
    logic [3:0]    in_valid = '0;
    logic [3:0]    in_ready;
    logic [31:0]   in_data  = '0;
    logic          xreq;
    logic [7:0]    xdata;
    logic [1:0]    xch;
    logic          xack;
    logic          busy;
    logic          err;
    logic          err_clr  = 1'b0;

    logic [2:0]    dst_q;
    logic          dst_en   = 1'b1;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            rr_m     = 0;
    logic [9:0]    exp_q[$];

    cdc_rr_hs_sender #(
        .NCH    (NCH),
        .DW     (DW),
        .SYNC_N (SYNC_N),
        .TO_W   (TO_W)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .xreq     (xreq),
        .xdata    (xdata),
        .xch      (xch),
        .xack     (xack),
        .busy     (busy),
        .err      (err),
        .err_clr  (err_clr)
    );

    always #5 clk = ~clk;

    // Destination echoes xreq back as xack after DST_DLY clocks.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) dst_q <= '0;
        else       dst_q <= {dst_q[1:0], xreq & dst_en};
    end
    assign xack = dst_q[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_grant(input logic [3:0] v);
        for (int i = 0; i < NCH; i++) begin
            int idx;
            idx = (rr_m + i) % NCH;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // Monitor: pop expectation on each xreq rise, then demand a frozen bus while busy.
    initial begin
        logic       have_cur;
        logic [9:0] cur;
        logic       xreq_prev;
        have_cur  = 1'b0;
        cur       = '0;
        xreq_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                have_cur  = 1'b0;
                xreq_prev = 1'b0;
            end else begin
                if (xreq && !xreq_prev) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_xfer", 32'(exp_q.size()), 32'd1);
                    end else begin
                        cur      = exp_q.pop_front();
                        have_cur = 1'b1;
                        check("xch", 32'(xch), 32'(cur[9:8]));
                        check("xdata", 32'(xdata), 32'(cur[7:0]));
                    end
                end
                if (busy && have_cur) begin
                    check("xdata_hold", 32'(xdata), 32'(cur[7:0]));
                    check("xch_hold", 32'(xch), 32'(cur[9:8]));
                end
                xreq_prev = xreq;
            end
        end
    end

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic wait_accept();
        int g;
        int n;
        n = 0;
        while (n < 200) begin
            #1;
            if (in_ready != 4'b0) break;
            in_data = $urandom;
            @(negedge clk);
            n++;
        end
        if (in_ready == 4'b0) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            return;
        end
        g = exp_grant(in_valid);
        check("in_ready", 32'(in_ready), (g < 0) ? 32'd0 : (32'd1 << g));
        if (g < 0) return;
        exp_q.push_back({2'(g), in_data[g*DW +: DW]});
        rr_m = (g + 1) % NCH;
        @(negedge clk);
        check("xreq_rise", 32'(xreq), 32'd1);
        check("busy_set", 32'(busy), 32'd1);
        check("in_ready_req", 32'(in_ready), 32'd0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            in_data = $urandom;
            @(negedge clk);
            n++;
        end
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic wait_err(input int c0, output int c);
        c = c0;
        while (!err && c < 64) begin
            in_data = $urandom;
            @(negedge clk);
            c++;
        end
    endtask

    initial begin
        int hi;
        int c;

        repeat (3) @(negedge clk);
        check("rst_xreq", 32'(xreq), 32'd0);
        check("rst_xdata", 32'(xdata), 32'd0);
        check("rst_xch", 32'(xch), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Fairness: all channels requesting for 8 transfers.
        in_valid = 4'hF;
        for (int k = 0; k < 8; k++) wait_accept();
        in_valid = 4'h0;
        wait_idle();

        // Single transfer on channel 2 with handshake timing.
        in_valid = 4'b0100;
        in_data  = 32'h00A5_0000;
        wait_accept();
        in_valid = 4'h0;
        check("t1_xch", 32'(xch), 32'd2);
        check("t1_xdata", 32'(xdata), 32'hA5);
        hi = 0;
        while (xreq && hi < 100) begin
            hi++;
            in_data = $urandom;
            @(negedge clk);
        end
        check("t1_xreq_cycles", 32'(hi), 32'(DST_DLY + SYNC_N + 1));
        hi = 0;
        while (busy && hi < 100) begin
            hi++;
            in_data = $urandom;
            @(negedge clk);
        end
        check("t1_rel_cycles", 32'(hi), 32'(DST_DLY + SYNC_N + 1));

        // Pointer sits at 3; ch3 idle so ch0 then ch1 win.
        in_valid = 4'b0011;
        wait_accept();
        check("t3_first", 32'(xch), 32'd0);
        wait_accept();
        check("t3_second", 32'(xch), 32'd1);
        in_valid = 4'h0;
        wait_idle();

        // Timeout: destination silent.
        dst_en   = 1'b0;
        in_valid = 4'b0001;
        wait_accept();
        in_valid = 4'h0;
        wait_err(1, c);
        check("to_cycles", 32'(c - 1), 32'((1 << TO_W) - 1));
        check("to_xreq", 32'(xreq), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_clr", 32'(err), 32'd0);
        wait_err(1, c);
        check("to_rearm_cycles", 32'(c - 1), 32'((1 << TO_W) - 1));
        check("to_rearm_xreq", 32'(xreq), 32'd1);

        // Asynchronous reset while REQ is outstanding.
        #2;
        rstn = 1'b0;
        #1;
        check("arst_xreq", 32'(xreq), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        dst_en = 1'b1;
        exp_q.delete();
        rr_m = 0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        in_valid = 4'hF;
        wait_accept();
        check("t6_first", 32'(xch), 32'd0);
        in_valid = 4'h0;
        wait_idle();

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
